// File: rtl/fifo_lib_pkg.sv
// fifo_lib_pkg: shared FIFO helpers (used-words counter width, threshold compare)
package fifo_lib_pkg;
  function automatic int used_w(input int addr_width);
    return addr_width + 1;
  endfunction
  function automatic logic thr_hit(input logic [31:0] cnt, input logic [31:0] thr, input logic ge);
    return ge ? (cnt >= thr) : (cnt <= thr);
  endfunction
endpackage

// File: rtl/dual_port_ram.sv
// dual_port_ram: simple dual-port RAM, one write port and one registered read port
// ports: wr_clk_i/wr_en_i/wr_addr_i/wr_data_i write side,
//        rd_clk_i/rd_en_i/rd_addr_i/rd_data_o read side (rd_data_o holds when rd_en_i=0)
module dual_port_ram #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  wr_clk_i,
  input  logic                  wr_en_i,
  input  logic [ADDR_WIDTH-1:0] wr_addr_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic                  rd_clk_i,
  input  logic                  rd_en_i,
  input  logic [ADDR_WIDTH-1:0] rd_addr_i,
  output logic [DATA_WIDTH-1:0] rd_data_o
);
  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
  always_ff @(posedge wr_clk_i)
    if (wr_en_i) mem[wr_addr_i] <= wr_data_i;
  always_ff @(posedge rd_clk_i)
    if (rd_en_i) rd_data_o <= mem[rd_addr_i];
endmodule

// File: rtl/sc_fifo_prog.sv
// sc_fifo_prog: single-clock show-ahead FIFO with programmable almost-full/empty thresholds
// ports: clk_i, rst_i (async, active-high); wr_i/wr_data_i push; rd_i pop, rd_data_o head word;
//        used_words_o, full_o, empty_o status; af_thr_i/ae_thr_i -> almost_full_o/almost_empty_o;
//        overflow_o/underflow_o sticky errors cleared by err_clr_i
// config: define SC_FIFO_PROG_ERR_FLAGS_EN to build the sticky error flags (otherwise tied to 0)
module sc_fifo_prog
  import fifo_lib_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int WORDS_AMOUNT = 8,
  parameter int ADDR_WIDTH   = $clog2(WORDS_AMOUNT)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic                  wr_i,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  input  logic                  rd_i,
  output logic [ADDR_WIDTH:0]   used_words_o,
  output logic                  full_o,
  output logic                  empty_o,
  input  logic [ADDR_WIDTH:0]   af_thr_i,
  input  logic [ADDR_WIDTH:0]   ae_thr_i,
  output logic                  almost_full_o,
  output logic                  almost_empty_o,
  output logic                  overflow_o,
  output logic                  underflow_o,
  input  logic                  err_clr_i
);
  localparam int CW = used_w(ADDR_WIDTH);
  logic [CW-1:0] used, wr_ptr, rd_ptr;
  logic [DATA_WIDTH-1:0] q, out_data;
  logic ram_vld, out_vld, wr_acc, pop, load, fetch;
  assign full_o = used == CW'(WORDS_AMOUNT);
  assign empty_o = !out_vld;
  assign used_words_o = used;
  assign rd_data_o = out_data;
  assign wr_acc = wr_i && !full_o;
  assign pop = rd_i && out_vld;
  // two-stage prefetch: RAM read register (ram_vld) feeds the show-ahead output register (out_vld)
  assign load = ram_vld && (!out_vld || pop);
  assign fetch = (wr_ptr != rd_ptr) && (!ram_vld || load);
  assign almost_full_o = thr_hit(32'(used), 32'(af_thr_i), 1'b1);
  assign almost_empty_o = thr_hit(32'(used), 32'(ae_thr_i), 1'b0);
  dual_port_ram #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_ram (
    .wr_clk_i (clk_i),
    .wr_en_i  (wr_acc),
    .wr_addr_i(wr_ptr[ADDR_WIDTH-1:0]),
    .wr_data_i(wr_data_i),
    .rd_clk_i (clk_i),
    .rd_en_i  (fetch),
    .rd_addr_i(rd_ptr[ADDR_WIDTH-1:0]),
    .rd_data_o(q)
  );
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      used <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      ram_vld <= 1'b0;
      out_vld <= 1'b0;
    end else begin
      used <= used + CW'(wr_acc) - CW'(pop);
      wr_ptr <= wr_acc ? wr_ptr + 1'b1 : wr_ptr;
      rd_ptr <= fetch ? rd_ptr + 1'b1 : rd_ptr;
      ram_vld <= fetch || (ram_vld && !load);
      out_vld <= load || (out_vld && !pop);
    end
  always_ff @(posedge clk_i)
    if (load) out_data <= q;
`ifdef SC_FIFO_PROG_ERR_FLAGS_EN
  logic ovf, udf;
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      ovf <= 1'b0;
      udf <= 1'b0;
    end else begin
      ovf <= (wr_i && full_o) || (ovf && !err_clr_i);
      udf <= (rd_i && !out_vld) || (udf && !err_clr_i);
    end
  assign overflow_o = ovf;
  assign underflow_o = udf;
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr_i;
  assign overflow_o = 1'b0;
  assign underflow_o = 1'b0;
`endif
endmodule
